// File: rtl/am_insert_lane_tx.sv
// Per-lane TX alignment marker inserter: every AM_GAP_N data blocks it takes one
// downstream slot for an unscrambled marker carrying the lane encoding and running BIP.
module am_insert_lane_tx #(
    parameter int          BLOCK_W  = 66,
    parameter int          AM_GAP_N = 16383,
    parameter int          CNT_W    = $clog2(AM_GAP_N),
    parameter logic [23:0] LANE_ENC = 24'h477690
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               slot_v_i,
    input  logic [BLOCK_W-1:0] data_i,
    output logic               ready_o,
    output logic               data_v_o,
    output logic [BLOCK_W-1:0] data_o,
    output logic               am_v_o
);

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_MARK = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_GAP_N - 1);

    // Bit positions that fold into BIP lane k; the sync header lands in lanes 3 and 4.
    function automatic logic [BLOCK_W-1:0] bip_mask(input int k);
        logic [BLOCK_W-1:0] m;
        m = '0;
        for (int j = 0; j < 8; j++) begin
            m[2 + k + 8 * j] = 1'b1;
        end
        if (k == 3) m[0] = 1'b1;
        if (k == 4) m[1] = 1'b1;
        return m;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         bip_q, bip_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic               data_v_q, data_v_d;
    logic               am_v_q, am_v_d;

    logic [BLOCK_W-1:0] am_block;
    logic [7:0]         bip_data;
    logic [7:0]         bip_am;

    assign am_block = {~bip_q, ~LANE_ENC[23:16], ~LANE_ENC[15:8], ~LANE_ENC[7:0],
                       bip_q, LANE_ENC[23:16], LANE_ENC[15:8], LANE_ENC[7:0], 2'b01};

    for (genvar gi = 0; gi < 8; gi++) begin : g_bip
        localparam logic [BLOCK_W-1:0] MASK = bip_mask(gi);
        assign bip_data[gi] = ^(data_i & MASK);
        assign bip_am[gi]   = ^(am_block & MASK);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= ST_MARK;
            cnt_q    <= '0;
            bip_q    <= 8'h00;
            data_q   <= '0;
            data_v_q <= 1'b0;
            am_v_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bip_q    <= bip_d;
            data_q   <= data_d;
            data_v_q <= data_v_d;
            am_v_q   <= am_v_d;
        end
    end

    // Next-state logic: slots with slot_v_i=0 freeze the period count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (slot_v_i) begin
            case (state_q)
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_MARK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_DATA;
                end
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        ready_o  = nreset & slot_v_i & (state_q == ST_DATA);
        data_v_d = slot_v_i;
        am_v_d   = 1'b0;
        data_d   = data_q;
        bip_d    = bip_q;
        if (slot_v_i) begin
            if (state_q == ST_DATA) begin
                data_d = data_i;
                bip_d  = bip_q ^ bip_data;
            end else begin
                data_d = am_block;
                am_v_d = 1'b1;
                // The marker itself seeds the parity for the next marker.
                bip_d  = bip_am;
            end
        end
    end

    assign data_v_o = data_v_q;
    assign data_o   = data_q;
    assign am_v_o   = am_v_q;

endmodule

// File: tb/tb_am_insert_lane_tx.sv
// Scoreboard bench for am_insert_lane_tx: two lanes (default and E6C4F0 encodings)
// driven in lockstep; stimulus pushes expected blocks, a monitor pops and compares.
module tb_am_insert_lane_tx;

    localparam int GAP = 4;
    localparam logic [23:0] ENC0 = 24'h477690;
    localparam logic [23:0] ENC1 = 24'hE6C4F0;
    localparam logic [65:0] HAND_AM0 = {64'hFFB8896F00477690, 2'b01};
    localparam logic [65:0] HAND_AM1 = {64'hFF193B0F00E6C4F0, 2'b01};

    logic        clk = 1'b0;
    logic        nreset;
    logic        slot_v_i;
    logic [65:0] data_i;
    logic        ready0, ready1, dv0, dv1, am0, am1;
    logic [65:0] do0, do1;

    always #5 clk = ~clk;

    am_insert_lane_tx #(.AM_GAP_N(GAP), .LANE_ENC(ENC0)) dut0 (
        .clk(clk), .nreset(nreset), .slot_v_i(slot_v_i), .data_i(data_i),
        .ready_o(ready0), .data_v_o(dv0), .data_o(do0), .am_v_o(am0));

    am_insert_lane_tx #(.AM_GAP_N(GAP), .LANE_ENC(ENC1)) dut1 (
        .clk(clk), .nreset(nreset), .slot_v_i(slot_v_i), .data_i(data_i),
        .ready_o(ready1), .data_v_o(dv1), .data_o(do1), .am_v_o(am1));

    typedef struct packed {
        logic        am;
        logic [65:0] d0;
        logic [65:0] d1;
    } exp_t;

    exp_t        exp_q[$];
    logic [65:0] src_q[$];
    int          n_vec = 0;
    int          n_miss = 0;

    function automatic logic [7:0] bip_ref(input logic [65:0] x);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++)
                p[k] = p[k] ^ x[2 + k + 8 * j];
        p[3] = p[3] ^ x[0];
        p[4] = p[4] ^ x[1];
        return p;
    endfunction

    function automatic logic [65:0] mk_am(input logic [23:0] enc, input logic [7:0] b);
        return {~b, ~enc[23:16], ~enc[15:8], ~enc[7:0], b, enc[23:16], enc[15:8], enc[7:0], 2'b01};
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model state
    logic       m_mark;
    int         m_cnt;
    logic [7:0] m_bip0, m_bip1;

    task automatic step(input logic slot, input logic rst_n);
        logic [95:0] r;
        logic [65:0] d;
        if (src_q.size() == 0) begin
            r = {$urandom, $urandom, $urandom};
            src_q.push_back(r[65:0]);
        end
        d = src_q[0];
        nreset   = rst_n;
        slot_v_i = slot;
        data_i   = d;
        #1;
        check("ready0", {65'd0, ready0}, {65'd0, rst_n & slot & ~m_mark});
        check("ready1", {65'd0, ready1}, {65'd0, rst_n & slot & ~m_mark});
        if (!rst_n) begin
            m_mark = 1'b1;
            m_cnt  = 0;
            m_bip0 = 8'h00;
            m_bip1 = 8'h00;
        end else if (slot) begin
            if (m_mark) begin
                exp_q.push_back('{am: 1'b1, d0: mk_am(ENC0, m_bip0), d1: mk_am(ENC1, m_bip1)});
                m_bip0 = bip_ref(mk_am(ENC0, m_bip0));
                m_bip1 = bip_ref(mk_am(ENC1, m_bip1));
                m_mark = 1'b0;
            end else begin
                exp_q.push_back('{am: 1'b0, d0: d, d1: d});
                m_bip0 = m_bip0 ^ bip_ref(d);
                m_bip1 = m_bip1 ^ bip_ref(d);
                void'(src_q.pop_front());
                if (m_cnt == GAP - 1) begin
                    m_cnt  = 0;
                    m_mark = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor
    logic        mon_v, mon_first;
    logic [65:0] last0, last1;
    exp_t        e;
    initial begin
        mon_first = 1'b1;
        last0 = '0;
        last1 = '0;
        forever begin
            @(posedge clk);
            mon_v = nreset & slot_v_i;
            if (!nreset) begin
                last0 = '0;
                last1 = '0;
                mon_first = 1'b1;
            end
            #1;
            check("data_v0", {65'd0, dv0}, {65'd0, mon_v});
            check("data_v1", {65'd0, dv1}, {65'd0, mon_v});
            if (mon_v) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_output: got %h with empty scoreboard", do0);
                end else begin
                    e = exp_q.pop_front();
                    check("am_v0", {65'd0, am0}, {65'd0, e.am});
                    check("am_v1", {65'd0, am1}, {65'd0, e.am});
                    check("data0", do0, e.d0);
                    check("data1", do1, e.d1);
                end
                if (mon_first) begin
                    check("first_am0", do0, HAND_AM0);
                    check("first_am1", do1, HAND_AM1);
                    mon_first = 1'b0;
                end
                last0 = do0;
                last1 = do1;
            end else begin
                check("am_idle0", {65'd0, am0}, 66'd0);
                check("am_idle1", {65'd0, am1}, 66'd0);
                check("hold0", do0, last0);
                check("hold1", do1, last1);
            end
        end
    end

    initial begin
        int guard;
        m_mark = 1'b1;
        m_cnt  = 0;
        m_bip0 = 8'h00;
        m_bip1 = 8'h00;
        src_q.push_back(66'h1);
        src_q.push_back(66'h3FFFFFFFFFFFFFFFC);
        src_q.push_back(66'h2);
        src_q.push_back({64'h0123456789ABCDEF, 2'b10});
        src_q.push_back({64'h8000000000000001, 2'b01});
        src_q.push_back({64'hFFFFFFFFFFFFFFFF, 2'b10});
        src_q.push_back({64'h00000000000000FF, 2'b01});
        src_q.push_back({64'hA5A5A5A5A5A5A5A5, 2'b10});

        // Reset, then continuous slots over three periods
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 3 * (GAP + 1) + 1; i++) step(1'b1, 1'b1);

        // Park in MARK with no slots, then release
        guard = 0;
        while (!m_mark && guard < 20) begin
            step(1'b1, 1'b1);
            guard++;
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Random slot pacing over ~10 periods
        for (int i = 0; i < 100; i++) step(1'($urandom_range(0, 1)), 1'b1);

        // Reset in the middle of a period (cnt=2)
        guard = 0;
        while (!(!m_mark && m_cnt == 2) && guard < 20) begin
            step(1'b1, 1'b1);
            guard++;
        end
        step(1'b1, 1'b0);
        for (int i = 0; i < 2 * (GAP + 1); i++) step(1'b1, 1'b1);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check("scoreboard_empty", 66'(exp_q.size()), 66'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
